// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: buffers mono FIR samples and serializes each into both slots of a Philips I2S frame.
module fir_i2s_tx #(
   parameter int WIDTH_data = 24,
   parameter int SLOT_BITS  = 32,
   parameter int SCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH_data-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  sclk,
   output logic                  lrclk,
   output logic                  sd,
   output logic                  underrun
);
   localparam int BW = $clog2(2*SLOT_BITS);
   localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
   logic [DW-1:0]         div_cnt_q;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  sclk_q, lrclk_q, lrclk_d, sd_q, sd_d, underrun_q, buf_full_q;
   logic [WIDTH_data-1:0] buf_q, frame_q, frame_d, sh_q, sh_d, src;
   logic                  tick, fall, wrap, load;
   always_comb begin
      tick      = div_cnt_q == DW'(SCLK_DIV-1);
      fall      = tick && sclk_q;
      wrap      = bit_cnt_q == BW'(2*SLOT_BITS-1);
      load      = fall && wrap;
      bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
      frame_d   = load ? (buf_full_q ? buf_q : '0) : frame_q;
      // each slot restarts the shifter from the frame; once emptied it shifts out the zero padding
      src       = (bit_cnt_d == '0 || bit_cnt_d == BW'(SLOT_BITS)) ? frame_d : sh_q;
      sh_d      = src << 1;
      sd_d      = src[WIDTH_data-1];
      lrclk_d   = bit_cnt_d >= BW'(SLOT_BITS-1) && bit_cnt_d <= BW'(2*SLOT_BITS-2);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q  <= '0;
         bit_cnt_q  <= BW'(2*SLOT_BITS-1);
         sclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         frame_q    <= '0;
         sh_q       <= '0;
      end else begin
         div_cnt_q  <= tick ? '0 : div_cnt_q + 1'b1;
         underrun_q <= load && !buf_full_q;
         frame_q    <= frame_d;
         if (tick) sclk_q <= ~sclk_q;
         if (fall) begin
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            sd_q      <= sd_d;
            sh_q      <= sh_d;
         end
         if (load && buf_full_q) buf_full_q <= 1'b0;
         else if (sample_valid && !buf_full_q) begin
            buf_full_q <= 1'b1;
            buf_q      <= sample_in;
         end
      end
   end
   assign sample_ready = ~buf_full_q;
   assign sclk         = sclk_q;
   assign lrclk        = lrclk_q;
   assign sd           = sd_q;
   assign underrun     = underrun_q;
endmodule

// File: tb/tb_fir_i2s_tx.sv
// tb_fir_i2s_tx: directed scenarios for the I2S transmitter with SCLK_DIV=2 (256 clk per frame).
module tb_fir_i2s_tx;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready, sclk, lrclk, sd, underrun;
   int          vecs = 0;
   int          errs = 0;
   localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;
   localparam logic [63:0] UR_FIRST = 64'h8000_0000_0000_0000;
   fir_i2s_tx #(.WIDTH_data(24), .SLOT_BITS(32), .SCLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .sclk(sclk), .lrclk(lrclk), .sd(sd), .underrun(underrun)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask
   // records one frame; bit k of the stream lands at position 63-k so vectors read MSB-first
   task automatic capture(input int first, output logic [63:0] sdv, output logic [63:0] lrv,
                          output logic [63:0] urv, output int urn, output logic rdy_first,
                          output logic rdy_next);
      sdv = '0; lrv = '0; urv = '0; urn = 0; rdy_first = 1'bx; rdy_next = 1'bx;
      for (int i = 0; i < 64; i++) begin
         for (int t = 0; t < (i == 0 ? first : 4); t++) begin
            tick();
            if (underrun === 1'b1) urn++;
            if (i == 1 && t == 0) rdy_next = sample_ready;
         end
         sdv[63-i] = sd;
         lrv[63-i] = lrclk;
         urv[63-i] = underrun;
         if (i == 0) rdy_first = sample_ready;
      end
   endtask
   task automatic test_reset();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      reset = 1'b1; sample_valid = 1'b1; sample_in = 24'hABCDEF;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 2) begin reset = 1'b0; sample_valid = 1'b0; end
         vecs++;
         if ({sclk, lrclk, sd, underrun, sample_ready} !== 5'b00001) begin
            errs++;
            $display("FAIL reset_outputs cycle %0d got %b want 00001", i, {sclk, lrclk, sd, underrun, sample_ready});
         end
      end
      capture(3, sdv, lrv, urv, urn, r0, r1);
      vecs++;
      if (sdv !== 64'h0 || urv !== UR_FIRST || urn !== 1) begin
         errs++;
         $display("FAIL reset_no_accept got sd=%h ur=%h n=%0d want 0 %h 1", sdv, urv, urn, UR_FIRST);
      end
   endtask
   task automatic test_single_frame();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      do_reset();
      sample_valid = 1'b1; sample_in = 24'hA5C3F1;
      tick();
      sample_valid = 1'b0;
      vecs++;
      if (sample_ready !== 1'b0) begin errs++; $display("FAIL single_ready_drop got %b want 0", sample_ready); end
      tick();
      tick();
      vecs++;
      if (sample_ready !== 1'b0) begin errs++; $display("FAIL single_ready_held got %b want 0", sample_ready); end
      capture(1, sdv, lrv, urv, urn, r0, r1);
      vecs++;
      if (sdv !== {24'hA5C3F1, 8'h0, 24'hA5C3F1, 8'h0}) begin
         errs++; $display("FAIL single_sd got %h want %h", sdv, {24'hA5C3F1, 8'h0, 24'hA5C3F1, 8'h0});
      end
      vecs++;
      if (lrv !== LR_EXP) begin errs++; $display("FAIL single_lrclk got %h want %h", lrv, LR_EXP); end
      vecs++;
      if (urn !== 0) begin errs++; $display("FAIL single_underrun got %0d want 0", urn); end
      vecs++;
      if (r0 !== 1'b1 || r1 !== 1'b1) begin errs++; $display("FAIL single_ready_return got %b%b want 11", r0, r1); end
   endtask
   task automatic test_starvation();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      do_reset();
      for (int f = 0; f < 2; f++) begin
         capture(4, sdv, lrv, urv, urn, r0, r1);
         vecs++;
         if (sdv !== 64'h0 || urv !== UR_FIRST || urn !== 1) begin
            errs++;
            $display("FAIL starve_frame%0d got sd=%h ur=%h n=%0d want 0 %h 1", f, sdv, urv, urn, UR_FIRST);
         end
         vecs++;
         if (lrv !== LR_EXP) begin errs++; $display("FAIL starve_lrclk%0d got %h want %h", f, lrv, LR_EXP); end
      end
   endtask
   task automatic test_back_to_back();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      do_reset();
      sample_valid = 1'b1; sample_in = 24'h7FFFFF;
      tick();
      sample_in = 24'h800000;
      vecs++;
      if (sample_ready !== 1'b0) begin errs++; $display("FAIL b2b_first_accept got %b want 0", sample_ready); end
      capture(3, sdv, lrv, urv, urn, r0, r1);
      vecs++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin errs++; $display("FAIL b2b_second_accept got %b%b want 10", r0, r1); end
      vecs++;
      if (sdv !== {24'h7FFFFF, 8'h0, 24'h7FFFFF, 8'h0} || urn !== 0) begin
         errs++; $display("FAIL b2b_frame1 got sd=%h n=%0d want %h 0", sdv, urn, {24'h7FFFFF, 8'h0, 24'h7FFFFF, 8'h0});
      end
      capture(4, sdv, lrv, urv, urn, r0, r1);
      sample_valid = 1'b0;
      vecs++;
      if (sdv !== {24'h800000, 8'h0, 24'h800000, 8'h0} || urn !== 0) begin
         errs++; $display("FAIL b2b_frame2 got sd=%h n=%0d want %h 0", sdv, urn, {24'h800000, 8'h0, 24'h800000, 8'h0});
      end
   endtask
   task automatic test_simultaneous();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      do_reset();
      capture(4, sdv, lrv, urv, urn, r0, r1);
      tick();
      tick();
      tick();
      sample_valid = 1'b1; sample_in = 24'h123456;
      capture(1, sdv, lrv, urv, urn, r0, r1);
      vecs++;
      if (sdv !== 64'h0 || urv !== UR_FIRST || urn !== 1) begin
         errs++; $display("FAIL simul_zero_frame got sd=%h ur=%h n=%0d want 0 %h 1", sdv, urv, urn, UR_FIRST);
      end
      vecs++;
      if (r0 !== 1'b0) begin errs++; $display("FAIL simul_accept got %b want 0", r0); end
      capture(4, sdv, lrv, urv, urn, r0, r1);
      sample_valid = 1'b0;
      vecs++;
      if (sdv !== {24'h123456, 8'h0, 24'h123456, 8'h0} || urn !== 0) begin
         errs++; $display("FAIL simul_next_frame got sd=%h n=%0d want %h 0", sdv, urn, {24'h123456, 8'h0, 24'h123456, 8'h0});
      end
   endtask
   task automatic test_mid_reset();
      logic [63:0] sdv, lrv, urv;
      int urn;
      logic r0, r1;
      do_reset();
      sample_valid = 1'b1; sample_in = 24'hFFFFFF;
      tick();
      sample_in = 24'h0F0F0F;
      repeat (43) tick();
      vecs++;
      if ({sd, lrclk, sample_ready} !== 3'b100) begin
         errs++; $display("FAIL mid_pre_reset got %b want 100", {sd, lrclk, sample_ready});
      end
      sample_valid = 1'b0;
      reset = 1'b1;
      tick();
      vecs++;
      if ({sclk, lrclk, sd, underrun, sample_ready} !== 5'b00001) begin
         errs++; $display("FAIL mid_reset_outputs got %b want 00001", {sclk, lrclk, sd, underrun, sample_ready});
      end
      reset = 1'b0;
      for (int f = 0; f < 2; f++) begin
         capture(4, sdv, lrv, urv, urn, r0, r1);
         vecs++;
         if (sdv !== 64'h0 || urv !== UR_FIRST || urn !== 1) begin
            errs++; $display("FAIL mid_after_frame%0d got sd=%h ur=%h n=%0d want 0 %h 1", f, sdv, urv, urn, UR_FIRST);
         end
      end
   endtask
   initial begin
      test_reset();
      test_single_frame();
      test_starvation();
      test_back_to_back();
      test_simultaneous();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/fir_i2s_tx.md
Name: fir_i2s_tx

Overview:
- Output-side transmitter for the FIR audio path.
- Accepts 24-bit signed filtered samples from the FIR output over a valid/ready handshake and serializes them as a Philips I2S stream: SCLK, LRCLK and SD.
- Mono source: each accepted sample is transmitted in both the left and right slots of one frame.
- Sits between the FIR data output and the board DAC/codec pins.

Parameters:
- WIDTH_data, 24: sample width in bits; transmitted MSB first.
- SLOT_BITS, 32: SCLK periods per channel slot. Must be >= WIDTH_data.
- SCLK_DIV, 4: clk cycles per SCLK half-period. Must be >= 1. SCLK period = 2*SCLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH_data  signed sample from the FIR.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  the holding buffer is empty and a sample can be accepted.
- sclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select; 0 = left, 1 = right.
- sd  output  1  I2S serial data.
- underrun  output  1  one-cycle pulse: a frame started with no sample buffered.

Behaviour:
- One clock, synchronous active-high reset. Every register below clears only when reset is sampled high on a clk edge.
- Reset values:
  - sclk=0, lrclk=0, sd=0, underrun=0, sample_ready=1.
  - Holding buffer empty; shift register 0; div_cnt=0; bit_cnt=2*SLOT_BITS-1.
- Clock divider:
  - div_cnt counts 0..SCLK_DIV-1.
  - On the edge where div_cnt==SCLK_DIV-1: sclk toggles and div_cnt returns to 0.
  - A "fall event" is a toggle while sclk==1.
  - After reset, sclk rises after SCLK_DIV cycles; the first fall is after 2*SCLK_DIV cycles.
- Bit counter:
  - On each fall event, bit_cnt advances modulo 2*SLOT_BITS.
  - A wrap from 2*SLOT_BITS-1 to 0 is the frame load.
- Handshake:
  - A transfer occurs on any edge with sample_valid && sample_ready.
  - The sample is written to the single-entry holding buffer; sample_ready goes 0 on the next cycle.
  - sample_in is ignored when sample_ready=0. The source must hold the sample until it is accepted.
- Frame load (same edge as the fall event with the new bit_cnt=0):
  - Buffer full: the sample is copied to the frame register and the buffer is freed; sample_ready=1 from the next cycle.
  - Buffer empty: the frame register is loaded with 0 and underrun=1 for exactly that one cycle.
- Simultaneous transfer and frame load on the same edge:
  - The load sees the pre-edge buffer state; there is no bypass.
  - If the buffer was empty, underrun fires and the frame is zeros; the incoming sample is stored for the next frame.
  - The buffer cannot be full and accepting at the same time, because sample_ready=0 when full.
- sd, updated only on fall events (changes while sclk goes low):
  - bit_cnt k in 0..WIDTH_data-1: frame[WIDTH_data-1-k], left slot.
  - k in WIDTH_data..SLOT_BITS-1: 0.
  - k in SLOT_BITS..SLOT_BITS+WIDTH_data-1: frame[WIDTH_data-1-(k-SLOT_BITS)], right slot, same sample.
  - Remaining k: 0.
- lrclk, updated on fall events with the I2S one-bit lead:
  - 1 when bit_cnt is in SLOT_BITS-1..2*SLOT_BITS-2.
  - 0 otherwise, including bit_cnt=2*SLOT_BITS-1, the last bit of the right slot.
- Frame timing:
  - Frame period = 2*SLOT_BITS*2*SCLK_DIV clk cycles.
  - Maximum sample rate = one sample per frame. A sustained faster source stalls on sample_ready.
- Reset mid-frame:
  - All state returns to reset values on the next edge.
  - The buffered sample and the partial frame are discarded; no underrun pulse.
- No arithmetic is performed on the sample; bits pass through unmodified (two's complement preserved).

Test Plan:
(all scenarios use WIDTH_data=24, SLOT_BITS=32, SCLK_DIV=2: 4 clk per SCLK, 256 clk per frame)
- Reset: hold reset 3 cycles with sample_valid=1 -> during and one cycle after, sclk=0, lrclk=0, sd=0, underrun=0, sample_ready=1, and no sample is accepted while reset=1.
- Single frame: present 0xA5C3F1 immediately after reset -> sample_ready drops next cycle. From the first fall, sd bits 0..23 = 1010_0101_1100_0011_1111_0001, bits 24..31 = 0, bits 32..55 repeat the sample, 56..63 = 0. lrclk=1 for bits 31..62. underrun stays 0. sample_ready returns to 1 one cycle after the first fall.
- Starvation: no sample after reset -> underrun=1 for exactly one cycle at clk 4 (first fall); sd=0 for the whole frame. Repeats every 256 clk while starved.
- Back-to-back: sample_valid held high with 0x7FFFFF then 0x800000 -> first accepted at once; second accepted on the cycle after the first frame load. Frames carry 0x7FFFFF then 0x800000 (sd = 0 then 23 ones; 1 then 23 zeros). No underrun between them.
- Simultaneous event: starve, then assert sample_valid with 0x123456 on exactly the frame-load edge -> underrun pulses and that frame is zeros; the next frame carries 0x123456.
- Mid-frame reset: assert reset at bit_cnt=10 of a frame carrying 0xFFFFFF with 0x0F0F0F buffered -> next cycle all outputs are at reset values. The first frame after release is zeros with underrun; 0x0F0F0F is never transmitted.
